bin2bcd_display: RTL and testbench



---
 rtl/bin2bcd_display_if.sv | 18 +
 rtl/bin2bcd_display.sv | 105 ++++++++++
 tb/tb_bin2bcd_display.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_display_if.sv
// Bus between the CPU datapath and the bin2bcd_display converter.
// The master side drives start/bin_in; the slave (converter) drives busy/done/ovf/bcd_out.
interface bin2bcd_display_if #(
    parameter int IN_W = 32
);
    // Handshake: start is taken only on an edge where busy is low. While busy is
    // high, start and bin_in are ignored. done pulses for one cycle on the edge
    // that updates bcd_out/ovf. bcd_out holds its value between done pulses.
    logic            start;
    logic [IN_W-1:0] bin_in;
    logic            busy;
    logic            done;
    logic            ovf;
    logic [31:0]     bcd_out;

    modport master (output start, bin_in, input busy, done, ovf, bcd_out);
    modport slave  (input start, bin_in, output busy, done, ovf, bcd_out);
endinterface

// File: rtl/bin2bcd_display.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, feeding DISPLAY_DATA.
// Optional macro BCD_SAT_EN: saturate bcd_out to 99999999 when the value overflows 8 digits.
module bin2bcd_display #(
    parameter int IN_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bin2bcd_display_if.slave      bus,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [IN_W-1:0] r_sh_bin;
    logic [39:0]     r_scratch;
    logic [39:0]     w_adj;
    logic [5:0]      r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_ovf;
    logic [31:0]     r_bcd;
    logic            w_last_shift;

    assign w_last_shift = (r_cnt == 6'(IN_W - 1));

    // A digit is at most 12 after correction, so each 4-bit add never carries out.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 10; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_SHIFT;
            S_SHIFT: if (w_last_shift) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_bin  <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_bcd     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sh_bin  <= bus.bin_in;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    {r_scratch, r_sh_bin} <= {w_adj[38:0], r_sh_bin, 1'b0};
                    r_cnt                 <= r_cnt + 6'd1;
                end
                S_DONE: begin
`ifdef BCD_SAT_EN
                    r_bcd <= (r_scratch[39:32] != 8'd0) ? 32'h9999_9999 : r_scratch[31:0];
`else
                    r_bcd <= r_scratch[31:0];
`endif
                    r_ovf  <= (r_scratch[39:32] != 8'd0);
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.ovf     = r_ovf;
    assign bus.bcd_out = r_bcd;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bin2bcd_display.sv
// Self-checking bench for bin2bcd_display (IN_W=32) against a decimal-arithmetic reference.
module tb_bin2bcd_display;

    localparam int IN_W = 32;
    localparam int LAT  = IN_W + 1;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         n_checks;
    int         n_pass;

    bin2bcd_display_if #(.IN_W(IN_W)) bus ();

    bin2bcd_display #(.IN_W(IN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_ovf(input logic [31:0] v);
        longint unsigned x;
        x = longint'(v);
        return (x > 64'd99999999);
    endfunction

    function automatic logic [31:0] ref_bcd(input logic [31:0] v);
        longint unsigned x;
        logic [31:0]     r;
        x = longint'(v);
`ifdef BCD_SAT_EN
        if (x > 64'd99999999) return 32'h9999_9999;
`endif
        x = x % 64'd100000000;
        r = '0;
        for (int d = 0; d < 8; d++) begin
            r[d*4 +: 4] = 4'(x % 64'd10);
            x = x / 64'd10;
        end
        return r;
    endfunction

    // Starts one conversion, scribbles on bin_in while busy, returns done latency and busy length.
    task automatic do_conv(input logic [31:0] v, output int lat, output int busy_cycles);
        bus.bin_in = v;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        busy_cycles = bus.busy ? 1 : 0;
        lat         = -1;
        for (int i = 1; i <= 60; i++) begin
            bus.bin_in = $urandom();
            @(posedge clk); #1;
            if (bus.done) begin
                lat = i;
                break;
            end
            if (bus.busy) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else n_pass++;
        n_checks++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", bus.ovf); else n_pass++;
        n_checks++; if (bus.bcd_out !== 32'h0) $display("FAIL reset_bcd got=%h exp=0", bus.bcd_out); else n_pass++;
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", dbg_state); else n_pass++;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        int lat, bc;
        do_conv(32'h0, lat, bc);
        n_checks++; if (lat !== LAT) $display("FAIL zero_latency got=%0d exp=%0d", lat, LAT); else n_pass++;
        n_checks++; if (bc !== LAT) $display("FAIL zero_busy_len got=%0d exp=%0d", bc, LAT); else n_pass++;
        n_checks++; if (bus.bcd_out !== 32'h0) $display("FAIL zero_bcd got=%h exp=0", bus.bcd_out); else n_pass++;
        n_checks++; if (bus.ovf !== 1'b0) $display("FAIL zero_ovf got=%b exp=0", bus.ovf); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL zero_done_pulse got=%b exp=0", bus.done); else n_pass++;
    endtask

    task automatic test_ignored_start();
        int lat;
        int extra;
        bus.bin_in = 32'h00BC614E;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            bus.start  = (i == 10);
            bus.bin_in = $urandom();
            @(posedge clk); #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        bus.start = 1'b0;
        n_checks++; if (lat !== LAT) $display("FAIL ign_latency got=%0d exp=%0d", lat, LAT); else n_pass++;
        n_checks++; if (bus.bcd_out !== 32'h12345678) $display("FAIL ign_bcd got=%h exp=12345678", bus.bcd_out); else n_pass++;
        n_checks++; if (bus.ovf !== 1'b0) $display("FAIL ign_ovf got=%b exp=0", bus.ovf); else n_pass++;
        extra = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) extra++;
        end
        n_checks++; if (extra !== 0) $display("FAIL ign_extra_activity got=%0d exp=0", extra); else n_pass++;
        n_checks++; if (bus.bcd_out !== 32'h12345678) $display("FAIL ign_hold got=%h exp=12345678", bus.bcd_out); else n_pass++;
    endtask

    task automatic test_boundaries();
        logic [31:0] vals [4];
        int lat, bc;
        vals[0] = 32'h05F5E0FF;
        vals[1] = 32'h05F5E100;
        vals[2] = 32'hFFFFFFFF;
        vals[3] = 32'h00000009;
        for (int k = 0; k < 4; k++) begin
            do_conv(vals[k], lat, bc);
            n_checks++; if (lat !== LAT) $display("FAIL bound_latency v=%h got=%0d exp=%0d", vals[k], lat, LAT); else n_pass++;
            n_checks++;
            if (bus.bcd_out !== ref_bcd(vals[k])) $display("FAIL bound_bcd v=%h got=%h exp=%h", vals[k], bus.bcd_out, ref_bcd(vals[k]));
            else n_pass++;
            n_checks++;
            if (bus.ovf !== ref_ovf(vals[k])) $display("FAIL bound_ovf v=%h got=%b exp=%b", vals[k], bus.ovf, ref_ovf(vals[k]));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        int lat, bc;
        for (int k = 0; k < 20; k++) begin
            case ($urandom_range(0, 2))
                0:       v = 32'($urandom_range(0, 999));
                1:       v = 32'($urandom_range(0, 99999999));
                default: v = $urandom();
            endcase
            do_conv(v, lat, bc);
            n_checks++; if (lat !== LAT) $display("FAIL rand_latency v=%h got=%0d exp=%0d", v, lat, LAT); else n_pass++;
            n_checks++;
            if (bus.bcd_out !== ref_bcd(v)) $display("FAIL rand_bcd v=%h got=%h exp=%h", v, bus.bcd_out, ref_bcd(v));
            else n_pass++;
            n_checks++;
            if (bus.ovf !== ref_ovf(v)) $display("FAIL rand_ovf v=%h got=%b exp=%b", v, bus.ovf, ref_ovf(v));
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        int lat, bc;
        int seen;
        do_conv(32'h00BC614E, lat, bc);
        n_checks++; if (bus.bcd_out !== 32'h12345678) $display("FAIL arst_pre_bcd got=%h exp=12345678", bus.bcd_out); else n_pass++;
        bus.bin_in = 32'h1;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL arst_busy got=%b exp=0", bus.busy); else n_pass++;
        n_checks++; if (bus.bcd_out !== 32'h0) $display("FAIL arst_bcd got=%h exp=0", bus.bcd_out); else n_pass++;
        n_checks++; if (bus.ovf !== 1'b0) $display("FAIL arst_ovf got=%b exp=0", bus.ovf); else n_pass++;
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL arst_state got=%0d exp=0", dbg_state); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL arst_no_done got=%0d exp=0", seen); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int          t_done [$];
        logic [31:0] v_done [$];
        logic [31:0] held;
        int          unstable;
        held     = bus.bcd_out;
        unstable = 0;
        bus.bin_in = 32'd42;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.bin_in = 32'd7;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                t_done.push_back(i);
                v_done.push_back(bus.bcd_out);
                held = bus.bcd_out;
                if (t_done.size() == 2) begin
                    bus.start = 1'b0;
                    break;
                end
            end else if (bus.bcd_out !== held) begin
                unstable++;
            end
        end
        bus.start = 1'b0;
        n_checks++; if (t_done.size() !== 2) $display("FAIL b2b_count got=%0d exp=2", t_done.size()); else n_pass++;
        if (t_done.size() == 2) begin
            n_checks++; if (t_done[0] !== LAT) $display("FAIL b2b_first_lat got=%0d exp=%0d", t_done[0], LAT); else n_pass++;
            n_checks++;
            if (t_done[1] - t_done[0] !== LAT + 1) $display("FAIL b2b_period got=%0d exp=%0d", t_done[1] - t_done[0], LAT + 1);
            else n_pass++;
            n_checks++; if (v_done[0] !== 32'h00000042) $display("FAIL b2b_val0 got=%h exp=00000042", v_done[0]); else n_pass++;
            n_checks++; if (v_done[1] !== 32'h00000007) $display("FAIL b2b_val1 got=%h exp=00000007", v_done[1]); else n_pass++;
        end
        n_checks++; if (unstable !== 0) $display("FAIL b2b_stable got=%0d exp=0", unstable); else n_pass++;
        repeat (40) @(posedge clk);
        #1;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL b2b_idle_after got=%b exp=0", bus.busy); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_zero();
        test_ignored_start();
        test_boundaries();
        test_random();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
